// File: rtl/rv32i_imem_pkg.sv
// Shared definitions for the RV32I instruction memory: NOP encoding and FSM states.
package rv32i_imem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_CLEAR = 2'd0,
    IMEM_RUN   = 2'd1,
    IMEM_LOAD  = 2'd2
  } imem_state_t;

endpackage

// File: rtl/rv32i_imem_ram.sv
// DEPTH x 32 simple dual-port RAM: one write port, one registered read port, no reset.
module rv32i_imem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Read data only updates on an enabled read, so it doubles as the stall-hold storage.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/rv32i_imem.sv
// Loadable instruction memory: post-reset NOP scrub, valid/ready program load,
// 1-cycle fetch with stall hold and misaligned/out-of-range fault reporting.
module rv32i_imem
  import rv32i_imem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_ready,
  input  logic             stall_i,
  output logic             inst_valid,
  output logic [31:0]      inst_o,
  output logic             inst_fault,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic             load_last,
  input  logic [31:0]      load_data,
  output logic             load_ready,
  output logic             load_done,
  output logic [IDX_W:0]   load_count
);

  // DEPTH is a power of two, so the last index is all ones.
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  imem_state_t      r_state;
  imem_state_t      w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   r_load_count;
  logic             r_load_done;
  logic             r_valid;
  logic             r_fault;
  logic             r_sel_ram;

  logic             w_fault;
  logic             w_fetch_acc;
  logic             w_we;
  logic [31:0]      w_wdata;
  logic             w_load_end;
  logic [31:0]      w_rdata;

  assign w_fault     = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:IDX_W+2] != '0);
  assign w_fetch_acc = fetch_req && fetch_ready;

  always_comb begin
    w_state_nxt = r_state;
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    w_we        = 1'b0;
    w_wdata     = NOP;
    w_load_end  = 1'b0;
    unique case (r_state)
      IMEM_CLEAR: begin
        w_we = 1'b1;
        if (r_ptr == LAST_IDX) w_state_nxt = IMEM_RUN;
      end
      IMEM_RUN: begin
        fetch_ready = !stall_i;
        if (load_start) w_state_nxt = IMEM_LOAD;
      end
      IMEM_LOAD: begin
        load_ready = 1'b1;
        w_we       = load_valid;
        w_wdata    = load_data;
        if (load_valid && (load_last || r_ptr == LAST_IDX)) begin
          w_load_end  = 1'b1;
          w_state_nxt = IMEM_RUN;
        end
      end
      default: w_state_nxt = IMEM_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IMEM_CLEAR;
      r_ptr        <= '0;
      r_load_count <= '0;
      r_load_done  <= 1'b0;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
      r_sel_ram    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_done <= w_load_end;
      case (r_state)
        IMEM_CLEAR: r_ptr <= r_ptr + 1'b1;
        IMEM_RUN: begin
          if (load_start) begin
            r_ptr        <= '0;
            r_load_count <= '0;
          end
        end
        IMEM_LOAD: begin
          if (load_valid) begin
            r_ptr        <= r_ptr + 1'b1;
            r_load_count <= r_load_count + 1'b1;
          end
        end
        default: r_ptr <= '0;
      endcase
      // Output flags hold during stall; r_sel_ram picks RAM data versus the NOP mux leg.
      if (!stall_i) begin
        r_valid   <= w_fetch_acc;
        r_fault   <= w_fetch_acc && w_fault;
        r_sel_ram <= w_fetch_acc && !w_fault;
      end
    end
  end

  rv32i_imem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we && !rst),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_fetch_acc && !w_fault),
    .i_raddr (fetch_pc[IDX_W+1:2]),
    .o_rdata (w_rdata)
  );

  assign inst_valid = r_valid;
  assign inst_fault = r_fault;
  assign inst_o     = r_sel_ram ? w_rdata : NOP;
  assign load_done  = r_load_done;
  assign load_count = r_load_count;

endmodule

// File: doc/rv32i_imem.md
# rv32i_imem

Parametrised, synchronous-read instruction memory for the RV32I core, replacing the hard-coded fetch ROM. It sits between the IF stage and an external program loader (UART/debug). Programs are written through a valid/ready load port instead of being fixed in RTL. Fetches use a request/valid handshake with stall-hold and fault reporting. After reset the whole array is scrubbed to NOP before any fetch is served.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit instruction words; must be a power of two, at least 4.
- IDX_W, $clog2(DEPTH): word-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- fetch_req  in  1  fetch request from IF.
- fetch_pc  in  32  byte address of the instruction.
- fetch_ready  out  1  fetch accepted this cycle when high together with fetch_req.
- stall_i  in  1  pipeline stall; holds the current fetch output.
- inst_valid  out  1  inst_o/inst_fault valid.
- inst_o  out  32  fetched instruction.
- inst_fault  out  1  misaligned or out-of-range fetch.
- load_start  in  1  begin program load at word 0.
- load_valid  in  1  load_data valid.
- load_last  in  1  marks the final load word.
- load_data  in  32  instruction word to write.
- load_ready  out  1  load word accepted when high together with load_valid.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  IDX_W+1  number of words written by the last or current load.

## Operation
- FSM states: CLEAR, RUN, LOAD.
- CLEAR:
  - Entered on rst.
  - Writes NOP (0x00000013) to entries 0..DEPTH-1, one per cycle, via an internal pointer.
  - After the write to DEPTH-1, moves to RUN.
  - fetch_ready=0, load_ready=0; load_start is ignored.
- RUN:
  - fetch_ready = !stall_i; load_ready=0.
  - load_start moves the FSM to LOAD next cycle, sets the pointer to 0 and load_count to 0.
  - A fetch accepted in the same cycle as load_start still completes normally.
- LOAD:
  - fetch_ready=0, load_ready=1.
  - Each accepted beat writes mem[ptr]=load_data, increments ptr and increments load_count.
  - The load ends on an accepted beat with load_last=1, or on an accepted write to DEPTH-1 (overflow truncation).
  - At load end: load_done pulses the next cycle and the FSM returns to RUN.
  - Words not rewritten keep their previous contents.
- Fetch accepted (fetch_req & fetch_ready):
  - Index = fetch_pc[IDX_W+1:2].
  - Fault if fetch_pc[1:0]!=0 or fetch_pc[31:IDX_W+2]!=0.
  - Next cycle: inst_valid=1. On a fault, inst_o=NOP and inst_fault=1. Otherwise inst_o=mem[index] and inst_fault=0.
- No fetch accepted and stall_i=0: next cycle inst_valid=0, inst_o=NOP, inst_fault=0.
- stall_i=1: inst_valid, inst_o and inst_fault hold their values.
- load_valid outside LOAD: ignored, no write.
- Reset mid-load: the partial load is abandoned, CLEAR rescrubs the array, and load_count returns to 0.

## Timing
- Reset values: inst_o=NOP, inst_valid=0, inst_fault=0, fetch_ready=0, load_ready=0, load_done=0, load_count=0; FSM=CLEAR.
- CLEAR lasts exactly DEPTH cycles after the cycle in which rst is sampled low. fetch_ready first rises in cycle DEPTH.
- Fetch latency is 1 cycle from acceptance to inst_valid. Throughput is 1 fetch per cycle in RUN when not stalled.
- fetch_ready is combinational from the FSM state and stall_i only, never from fetch_req.
- Load throughput is 1 word per cycle. load_done is asserted the cycle after the final beat, in the same cycle the FSM is back in RUN.
- Read-during-load is impossible because fetch_ready=0 in LOAD. The RAM never sees a same-address read and write in one cycle.

## Structure
- Shared package (DEFINES): NOP encoding and the FSM state encodings IMEM_CLEAR, IMEM_RUN, IMEM_LOAD.
- Sub-module rv32i_imem_ram: simple dual-port synchronous RAM (DEPTH x 32) with one write port and one registered read port. It has no reset.
- The top level holds the FSM, pointer, fault logic, the output-hold register and the NOP mux.

## Test plan
- Reset then idle, DEPTH=16:
  - fetch_ready stays 0 for 16 cycles after rst falls, then rises.
  - A fetch of pc=0x0 returns inst_valid=1, inst_o=0x00000013.
- Load 3 words 0x00C00093, 0x02200113, 0x002081B3 with load_last on the third:
  - load_count=3 and load_done pulses once.
  - Fetches of pc 0x0/0x4/0x8 on consecutive cycles return those words back-to-back with 1-cycle latency.
- Fetch pc=0x6 and pc=DEPTH*4:
  - Each gives inst_valid=1, inst_fault=1, inst_o=0x00000013.
- Fetch pc=0x4, then stall_i=1 for 3 cycles while fetch_req stays high with pc=0x8:
  - inst_o holds the 0x4 word and fetch_ready=0.
  - After release, the 0x8 word appears one cycle later.
- Load of DEPTH+2 words with no load_last:
  - Truncates at DEPTH words, load_count=DEPTH, load_done pulses.
  - The extra beats are not accepted (load_ready=0).
- rst asserted after 2 of 5 load words:
  - CLEAR reruns and load_count=0.
  - A fetch of pc=0x0 after CLEAR returns NOP.
